// File: rtl/token_manager.sv
// Parking-token manager: hands out the lowest free slot with token = slot ^ pattern,
// and frees a slot only when the exiting car presents the matching slot/token pair.
module token_manager #(
  parameter int SLOT_W       = 3,
  parameter int NUM_SLOTS    = 8,
  parameter int PATTERN_MODE = 1,
  parameter int PAT_SEED     = 5,
  parameter int PAT_STEP     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enter_req,
  input  logic [SLOT_W-1:0] pattern_in,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  input  logic [SLOT_W-1:0] exit_token,
  output logic              token_valid,
  output logic [SLOT_W-1:0] token,
  output logic [SLOT_W-1:0] slot_out,
  output logic              enter_full,
  output logic              exit_ok,
  output logic              exit_err,
  output logic [SLOT_W:0]   free_count,
  output logic              full
);

  localparam logic [SLOT_W-1:0] SEED = SLOT_W'(PAT_SEED);
  localparam logic [SLOT_W-1:0] STEP = SLOT_W'(PAT_STEP);
  localparam logic [SLOT_W:0]   NUM  = (SLOT_W+1)'(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] r_occ;
  logic [SLOT_W-1:0]    r_pat_mem [NUM_SLOTS];
  logic [SLOT_W-1:0]    r_pat;

  logic                 w_alloc_found;
  logic [SLOT_W-1:0]    w_alloc_slot;
  logic [SLOT_W-1:0]    w_pat;
  logic                 w_grant;
  logic                 w_exit_match;
  logic [NUM_SLOTS-1:0] w_occ_next;
  logic [SLOT_W:0]      w_free_next;

  // Both the allocation and the exit check look at the occupancy before this edge,
  // so a slot released this cycle cannot be handed out in the same cycle.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_alloc_found = 1'b0;
    w_alloc_slot  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_occ[i]) begin
        w_alloc_found = 1'b1;
        w_alloc_slot  = SLOT_W'(i);
      end
    end

    w_pat   = (PATTERN_MODE != 0) ? r_pat : pattern_in;
    w_grant = enter_req && w_alloc_found;

    // Slot numbers at or above NUM_SLOTS never match any loop index, so they are rejected.
    w_exit_match = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (exit_slot == SLOT_W'(i) && r_occ[i] &&
          exit_token == (exit_slot ^ r_pat_mem[i]))
        w_exit_match = 1'b1;
    end

    w_occ_next = r_occ;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_grant && w_alloc_slot == SLOT_W'(i))
        w_occ_next[i] = 1'b1;
      if (exit_req && w_exit_match && exit_slot == SLOT_W'(i))
        w_occ_next[i] = 1'b0;
    end

    w_free_next = free_count - (SLOT_W+1)'(w_grant)
                             + (SLOT_W+1)'(exit_req && w_exit_match);
  end

  // NOTE: the pattern memory is small and its cleared state is architecturally
  // visible, so it is reset together with the rest of the state.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ       <= '0;
      r_pat       <= SEED;
      for (int i = 0; i < NUM_SLOTS; i++) r_pat_mem[i] <= '0;
      token_valid <= 1'b0;
      token       <= '0;
      slot_out    <= '0;
      enter_full  <= 1'b0;
      exit_ok     <= 1'b0;
      exit_err    <= 1'b0;
      free_count  <= NUM;
      full        <= (NUM == '0);
    end else begin
      token_valid <= w_grant;
      enter_full  <= enter_req && !w_alloc_found;
      exit_ok     <= exit_req && w_exit_match;
      exit_err    <= exit_req && !w_exit_match;
      r_occ       <= w_occ_next;
      free_count  <= w_free_next;
      full        <= (w_free_next == '0);
      if (w_grant) begin
        token    <= w_alloc_slot ^ w_pat;
        slot_out <= w_alloc_slot;
        if (PATTERN_MODE != 0) r_pat <= r_pat + STEP;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_grant && w_alloc_slot == SLOT_W'(i)) r_pat_mem[i] <= w_pat;
      end
    end
  end

endmodule

// File: tb/tb_token_manager.sv
// Bench for token_manager: an internal-pattern and an external-pattern instance share
// the same stimulus; each is compared every cycle against a slot-table model.
module tb_token_manager;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enter_req;
  logic [2:0] pattern_in;
  logic       exit_req;
  logic [2:0] exit_slot;
  logic [2:0] exit_token;

  logic       tv   [2];
  logic [2:0] tok  [2];
  logic [2:0] slot [2];
  logic       ef   [2];
  logic       ok   [2];
  logic       er   [2];
  logic [3:0] fc   [2];
  logic       fl   [2];

  always #5 clk = ~clk;

  token_manager #(.SLOT_W(3), .NUM_SLOTS(N), .PATTERN_MODE(0), .PAT_SEED(5), .PAT_STEP(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .enter_req(enter_req), .pattern_in(pattern_in),
    .exit_req(exit_req), .exit_slot(exit_slot), .exit_token(exit_token),
    .token_valid(tv[0]), .token(tok[0]), .slot_out(slot[0]), .enter_full(ef[0]),
    .exit_ok(ok[0]), .exit_err(er[0]), .free_count(fc[0]), .full(fl[0]));

  token_manager #(.SLOT_W(3), .NUM_SLOTS(N), .PATTERN_MODE(1), .PAT_SEED(5), .PAT_STEP(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .enter_req(enter_req), .pattern_in(pattern_in),
    .exit_req(exit_req), .exit_slot(exit_slot), .exit_token(exit_token),
    .token_valid(tv[1]), .token(tok[1]), .slot_out(slot[1]), .enter_full(ef[1]),
    .exit_ok(ok[1]), .exit_err(er[1]), .free_count(fc[1]), .full(fl[1]));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per mode: slot table, stored patterns, pattern register, last token.
  int m_occ [2][N];
  int m_pm  [2][N];
  int m_pr  [2];
  int m_tok [2];
  int m_slot[2];
  int e_tv[2], e_ef[2], e_ok[2], e_er[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin
        m_occ[m][i] = 0;
        m_pm[m][i]  = 0;
      end
      m_pr[m] = 5; m_tok[m] = 0; m_slot[m] = 0;
      e_tv[m] = 0; e_ef[m] = 0; e_ok[m] = 0; e_er[m] = 0;
    end
  endtask

  task automatic model_step(input int m, input bit en, input int pin,
                            input bit ex, input int es, input int et);
    bit accept;
    int s;
    int p;
    accept = ex && es < N && m_occ[m][es] != 0 && et == (es ^ m_pm[m][es]);
    e_ok[m] = accept;
    e_er[m] = ex && !accept;
    e_tv[m] = 0;
    e_ef[m] = 0;
    if (en) begin
      s = -1;
      for (int i = 0; i < N; i++) if (m_occ[m][i] == 0 && s < 0) s = i;
      if (s >= 0) begin
        p = (m == 1) ? m_pr[m] : pin;
        m_pm[m][s]  = p;
        m_occ[m][s] = 1;
        m_tok[m]    = s ^ p;
        m_slot[m]   = s;
        e_tv[m]     = 1;
        if (m == 1) m_pr[m] = (m_pr[m] + 3) % 8;
      end else begin
        e_ef[m] = 1;
      end
    end
    if (accept) m_occ[m][es] = 0;
  endtask

  task automatic check_outputs(input string tag);
    int free;
    for (int m = 0; m < 2; m++) begin
      free = 0;
      for (int i = 0; i < N; i++) if (m_occ[m][i] == 0) free++;
      check($sformatf("%s.m%0d.token_valid", tag, m), 32'(tv[m]),   e_tv[m]);
      check($sformatf("%s.m%0d.token", tag, m),       32'(tok[m]),  m_tok[m]);
      check($sformatf("%s.m%0d.slot_out", tag, m),    32'(slot[m]), m_slot[m]);
      check($sformatf("%s.m%0d.enter_full", tag, m),  32'(ef[m]),   e_ef[m]);
      check($sformatf("%s.m%0d.exit_ok", tag, m),     32'(ok[m]),   e_ok[m]);
      check($sformatf("%s.m%0d.exit_err", tag, m),    32'(er[m]),   e_er[m]);
      check($sformatf("%s.m%0d.free_count", tag, m),  32'(fc[m]),   free);
      check($sformatf("%s.m%0d.full", tag, m),        32'(fl[m]),   (free == 0) ? 1 : 0);
    end
  endtask

  // One clock of stimulus: drive after the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input string tag, input bit en, input int pin,
                       input bit ex, input int es, input int et);
    @(negedge clk);
    enter_req  = en;
    pattern_in = 3'(pin);
    exit_req   = ex;
    exit_slot  = 3'(es);
    exit_token = 3'(et);
    model_step(0, en, pin, ex, es, et);
    model_step(1, en, pin, ex, es, et);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int tok3;
    int rs;
    rst_n = 1'b0;
    enter_req = 0; pattern_in = 0; exit_req = 0; exit_slot = 0; exit_token = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Two entries: internal pattern 5 then 0; external pattern 2 for the first.
    cycle("enter1", 1, 2, 0, 0, 0);
    check("enter1.m1.token_const", 32'(tok[1]), 5);
    check("enter1.m0.token_const", 32'(tok[0]), 2);
    cycle("enter2", 1, 6, 0, 0, 0);
    check("enter2.m1.token_const", 32'(tok[1]), 1);
    check("enter2.m1.slot_const", 32'(slot[1]), 1);

    cycle("exit0",       0, 0, 1, 0, 5);
    check("exit0.m1.free_const", 32'(fc[1]), 7);
    cycle("exit0_again", 0, 0, 1, 0, 5);
    check("exit0_again.m1.err_const", 32'(er[1]), 1);
    cycle("exit1_bad",   0, 0, 1, 1, 0);
    cycle("exit0_ext",   0, 0, 1, 0, 2);
    check("exit0_ext.m0.ok_const", 32'(ok[0]), 1);

    // Fill to capacity; the last entry is rejected.
    for (int k = 0; k < 8; k++) cycle($sformatf("fill%0d", k), 1, k, 0, 0, 0);
    check("fill.m1.full_const", 32'(fl[1]), 1);
    check("fill.m1.enter_full_const", 32'(ef[1]), 1);

    // Entry and valid exit of slot 3 together, then slot 3 is reused.
    tok3 = 3 ^ m_pm[1][3];
    cycle("enter_exit", 1, 0, 1, 3, tok3);
    check("enter_exit.m1.ok_const", 32'(ok[1]), 1);
    cycle("reuse3", 1, 0, 0, 0, 0);
    check("reuse3.m1.slot_const", 32'(slot[1]), 3);

    // Reset asserted right after a request edge: nothing emerges after release.
    @(negedge clk);
    enter_req = 1; exit_req = 1; exit_slot = 3; exit_token = 3'(3 ^ m_pm[1][3]);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("midrst");
    @(posedge clk);
    #1;
    check_outputs("midrst_hold");
    @(negedge clk);
    enter_req = 0; exit_req = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("midrst_release");
    cycle("post_rst_enter", 1, 4, 0, 0, 0);
    check("post_rst_enter.m1.token_const", 32'(tok[1]), 5);

    // Randomized traffic; exits mostly present the correct internal-mode token.
    for (int k = 0; k < 400; k++) begin
      rs = $urandom_range(0, 7);
      cycle("rand", 1'($urandom_range(0, 99) < 55), $urandom_range(0, 7),
            1'($urandom_range(0, 99) < 50), rs,
            ($urandom_range(0, 9) < 7) ? (rs ^ m_pm[$urandom_range(0, 1)][rs])
                                       : $urandom_range(0, 7));
    end
    cycle("idle", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/token_manager.md
Name: token_manager

Overview:
- Parametrised parking-token manager: allocates a free park slot on entry, issues a token = slot XOR pattern, and stores the pattern per slot.
- On exit, checks the presented slot/token pair against the stored pattern and releases the slot only on a match.
- Pattern comes from an external input or an internal stepping generator, selected by parameter.
- Sits between the entry/exit gate controllers and the display/occupancy logic.

Parameters:
- SLOT_W, 3: width of slot number, pattern and token.
- NUM_SLOTS, 8: number of park slots; 1 <= NUM_SLOTS <= 2^SLOT_W.
- PATTERN_MODE, 1: 0 = use pattern_in; 1 = internal pattern register.
- PAT_SEED, 5: reset value of the internal pattern register (SLOT_W bits).
- PAT_STEP, 3: increment applied to the internal pattern after each successful issue, modulo 2^SLOT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enter_req  in  1  one-cycle entry request.
- pattern_in  in  SLOT_W  external pattern, sampled with enter_req when PATTERN_MODE=0; ignored otherwise.
- exit_req  in  1  one-cycle exit request.
- exit_slot  in  SLOT_W  slot claimed by the exiting car.
- exit_token  in  SLOT_W  token presented by the exiting car.
- token_valid  out  1  one-cycle pulse: token/slot_out valid.
- token  out  SLOT_W  issued token.
- slot_out  out  SLOT_W  allocated slot.
- enter_full  out  1  one-cycle pulse: entry rejected, no free slot.
- exit_ok  out  1  one-cycle pulse: exit accepted, slot freed.
- exit_err  out  1  one-cycle pulse: exit rejected.
- free_count  out  SLOT_W+1  number of free slots.
- full  out  1  high when free_count == 0.

Behaviour:
- Reset (async, rst_n=0):
  - occupancy vector cleared; per-slot pattern memory cleared.
  - Internal pattern register = PAT_SEED.
  - All pulse outputs 0; token = 0; slot_out = 0.
  - free_count = NUM_SLOTS; full = 0.
- Reset asserted mid-operation aborts any pending response; no pulse is emitted after release for requests sampled before reset.
- Entry (enter_req sampled high at edge N; responses are registered and appear after edge N+1's inputs settle, i.e. latency 1):
  - If any slot is free: allocate the lowest-index free slot s.
    - Pattern p = pattern register (mode 1) or pattern_in (mode 0).
    - Store pat_mem[s] = p and set occupied[s].
    - Pulse token_valid with token = s XOR p and slot_out = s.
    - Mode 1 only: pattern register advances by PAT_STEP (wraps mod 2^SLOT_W).
  - If no slot is free: pulse enter_full. Pattern register does not advance; token/slot_out hold their previous values.
- Exit (exit_req sampled high, latency 1):
  - Accepted iff exit_slot < NUM_SLOTS, occupied[exit_slot] = 1, and exit_token == exit_slot XOR pat_mem[exit_slot].
  - Accepted: clear occupied[exit_slot] and pulse exit_ok.
  - Otherwise: pulse exit_err; state unchanged.
- Simultaneous enter_req and exit_req in the same cycle:
  - Both are processed.
  - Allocation sees occupancy before the exit, so a slot freed this cycle is not reusable until the next request.
  - free_count = old − (entry granted) + (exit accepted).
- free_count and full are registered and consistent with occupancy after each edge; they never go below 0 or above NUM_SLOTS.
- token_valid and enter_full are mutually exclusive. exit_ok and exit_err are mutually exclusive.
- Back-to-back requests every cycle are supported; no request is dropped.

Test Plan:
- Reset: hold rst_n=0 -> all pulses 0, free_count=8, full=0; internal pattern = 3'b101.
- Mode 1, two enters:
  - First -> token_valid, slot_out=0, token=3'b101.
  - Second -> slot_out=1, pattern 3'b000, token=3'b001.
- Exit and double exit:
  - Exit slot 0 with token 3'b101 -> exit_ok, free_count 6→7.
  - Repeat the same exit -> exit_err, free_count stays 7.
  - Exit slot 1 with token 3'b000 -> exit_err, slot 1 stays occupied.
- Fill to capacity:
  - 8 enters -> full=1, free_count=0.
  - 9th enter -> enter_full, pattern register unchanged.
  - Same cycle enter + valid exit of slot 3 -> enter_full and exit_ok together; next enter -> slot_out=3.
- Mode 0: pattern_in=3'b010 on first enter -> slot_out=0, token=3'b010; exit slot 0 with token 3'b010 -> exit_ok.
- Async reset mid-operation: assert rst_n=0 between a request edge and its response -> no pulse after release; free_count=8; next enter -> slot 0 with PAT_SEED pattern.
